// File: rtl/fm_write_ctrl.sv
// Output feature-map write controller: valid/ready beats in, FM buffer writes out.
// Optional build macro FM_WRITE_RELU_EN clamps negative elements to zero on write.
module fm_write_ctrl #(
  parameter int FEATURE_ROWS   = 6,
  parameter int WEIGHT_COLS    = 3,
  parameter int DOT_PROD_WIDTH = 16,
  parameter int ADDRESS_WIDTH  = 13,
  parameter int FM_BASE_ADDR   = 0,
  parameter int COUNTER_ROW_WIDTH =
    (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1,
  parameter int COUNTER_COL_WIDTH =
    (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DOT_PROD_WIDTH-1:0]    in_data,
  output logic                         wr_en,
  output logic [ADDRESS_WIDTH-1:0]     wr_address,
  output logic [DOT_PROD_WIDTH-1:0]    wr_data,
  output logic [COUNTER_ROW_WIDTH-1:0] write_row,
  output logic [COUNTER_COL_WIDTH-1:0] write_col,
  output logic                         done
);

  localparam int RW = COUNTER_ROW_WIDTH;
  localparam int CW = COUNTER_COL_WIDTH;
  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DOT_PROD_WIDTH;

  localparam logic [RW-1:0] ROW_LAST = RW'(FEATURE_ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(WEIGHT_COLS - 1);
  localparam logic [AW-1:0] BASE     = AW'(FM_BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [AW-1:0] addr_q, addr_d;

  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic [RW-1:0] wr_row_q, wr_row_d;
  logic [CW-1:0] wr_col_q, wr_col_d;

  logic [DW-1:0] elem;

`ifdef FM_WRITE_RELU_EN
  assign elem = in_data[DW-1] ? '0 : in_data;
`else
  assign elem = in_data;
`endif

  assign in_ready   = (state_q == S_WRITE);
  assign done       = (state_q == S_DONE);
  assign wr_en      = wr_en_q;
  assign wr_address = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign write_row  = wr_row_q;
  assign write_col  = wr_col_q;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_row_d  = wr_row_q;
    wr_col_d  = wr_col_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WRITE;
          row_d   = '0;
          col_d   = '0;
          addr_d  = BASE;
        end
      end
      S_WRITE: begin
        if (in_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = elem;
          wr_row_d  = row_q;
          wr_col_d  = col_q;
          addr_d    = addr_q + AW'(1);
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              // last element: counters and address rewind for the next pass
              row_d   = '0;
              addr_d  = BASE;
              state_d = S_DONE;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      addr_q    <= BASE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_row_q  <= wr_row_d;
      wr_col_q  <= wr_col_d;
    end
  end

endmodule
